// File: rtl/wb_stage_if.sv
// Writeback stage bundle: upstream instruction handshake, memory read
// response channel, register-file write port, and retire/status outputs.
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
);
  // Upstream (EX/MEM) instruction handshake
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [RA_W-1:0]  in_rd;
  logic             in_rd_we;
  logic [XLEN-1:0]  in_alu_res;
  logic             in_is_load;
  logic [2:0]       in_ld_func;
  logic [1:0]       in_addr_lo;

  // Memory read response
  logic             mem_rvalid;
  logic             mem_rready;
  logic [XLEN-1:0]  mem_rdata;

  // Register file write port and retire status
  logic             we;
  logic [RA_W-1:0]  waddr;
  logic [XLEN-1:0]  wdata;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic             load_err;
  logic [CNT_W-1:0] instret;

  // Upstream / memory side that feeds the stage
  modport master (
    output in_valid, in_pc, in_rd, in_rd_we, in_alu_res, in_is_load,
           in_ld_func, in_addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, mem_rready, we, waddr, wdata, retire_valid,
           retire_pc, load_err, instret
  );

  // The writeback stage itself
  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_we, in_alu_res, in_is_load,
           in_ld_func, in_addr_lo, mem_rvalid, mem_rdata,
    output in_ready, mem_rready, we, waddr, wdata, retire_valid,
           retire_pc, load_err, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage of the single-issue NPC core. Takes one completed
// instruction per handshake, waits for the memory response on loads,
// extracts/extends load data and drives the register file write port,
// a retire pulse and the retired-instruction counter.
// All write/retire outputs are registers, updated on the edge that
// enters WRITE, so nothing combinational reaches them from in_*/mem_*.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  wb_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_e;

  state_e           state_q, state_d;

  // Latched instruction fields
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             rd_we_q, rd_we_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [2:0]       ld_func_q, ld_func_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic             err_q, err_d;

  // Registered outputs
  logic             we_q, we_d;
  logic [RA_W-1:0]  waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic             retire_valid_q, retire_valid_d;
  logic [XLEN-1:0]  retire_pc_q, retire_pc_d;
  logic             load_err_q, load_err_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic             in_ready_s;
  logic             accept_s;
  logic [XLEN:0]    ld_s;   // {err, data}

  // Load data extraction: returns {err, data}; data is zero on error.
  function automatic logic [XLEN:0] load_extract(
    input logic [2:0]      func,
    input logic [1:0]      lo,
    input logic [XLEN-1:0] word
  );
    logic [7:0]    b;
    logic [15:0]   h;
    logic [XLEN:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    r = {1'b1, {XLEN{1'b0}}};
    case (func)
      3'b000: r = {1'b0, {(XLEN-8){b[7]}}, b};
      3'b100: r = {1'b0, {(XLEN-8){1'b0}}, b};
      3'b001: begin
        if (lo[0]) r = {1'b1, {XLEN{1'b0}}};
        else       r = {1'b0, {(XLEN-16){h[15]}}, h};
      end
      3'b101: begin
        if (lo[0]) r = {1'b1, {XLEN{1'b0}}};
        else       r = {1'b0, {(XLEN-16){1'b0}}, h};
      end
      3'b010: begin
        if (lo != 2'b00) r = {1'b1, {XLEN{1'b0}}};
        else             r = {1'b0, word};
      end
      default: r = {1'b1, {XLEN{1'b0}}};
    endcase
    return r;
  endfunction

  assign in_ready_s     = (state_q == IDLE) || (state_q == WRITE);
  assign bus.in_ready   = in_ready_s;
  assign bus.mem_rready = (state_q == WAIT_MEM);

  assign bus.we           = we_q;
  assign bus.waddr        = waddr_q;
  assign bus.wdata        = wdata_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_pc    = retire_pc_q;
  assign bus.load_err     = load_err_q;
  assign bus.instret      = instret_q;

  // Next-state, field latching and registered-output next values
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    res_d     = res_q;
    ld_func_d = ld_func_q;
    addr_lo_d = addr_lo_q;
    err_d     = err_q;
    accept_s  = bus.in_valid && in_ready_s;
    ld_s      = load_extract(ld_func_q, addr_lo_q, bus.mem_rdata);

    case (state_q)
      IDLE, WRITE: begin
        if (accept_s) begin
          pc_d      = bus.in_pc;
          rd_d      = bus.in_rd;
          rd_we_d   = bus.in_rd_we;
          res_d     = bus.in_alu_res;
          ld_func_d = bus.in_ld_func;
          addr_lo_d = bus.in_addr_lo;
          err_d     = 1'b0;
          if (bus.in_is_load) state_d = WAIT_MEM;
          else                state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          res_d   = ld_s[XLEN-1:0];
          err_d   = ld_s[XLEN];
          state_d = WRITE;
        end else begin
          state_d = WAIT_MEM;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs take their WRITE-cycle values on the edge that enters WRITE
    we_d           = 1'b0;
    retire_valid_d = 1'b0;
    load_err_d     = 1'b0;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    retire_pc_d    = retire_pc_q;
    instret_d      = instret_q;
    if (state_d == WRITE) begin
      we_d           = rd_we_d && (rd_d != {RA_W{1'b0}}) && !err_d;
      waddr_d        = rd_d;
      wdata_d        = res_d;
      retire_valid_d = 1'b1;
      retire_pc_d    = pc_d;
      load_err_d     = err_d;
      instret_d      = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d      = instret_q;
    end
  end

  // State, latched fields and outputs; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= {XLEN{1'b0}};
      rd_q           <= {RA_W{1'b0}};
      rd_we_q        <= 1'b0;
      res_q          <= {XLEN{1'b0}};
      ld_func_q      <= 3'b000;
      addr_lo_q      <= 2'b00;
      err_q          <= 1'b0;
      we_q           <= 1'b0;
      waddr_q        <= {RA_W{1'b0}};
      wdata_q        <= {XLEN{1'b0}};
      retire_valid_q <= 1'b0;
      retire_pc_q    <= {XLEN{1'b0}};
      load_err_q     <= 1'b0;
      instret_q      <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      rd_q           <= rd_d;
      rd_we_q        <= rd_we_d;
      res_q          <= res_d;
      ld_func_q      <= ld_func_d;
      addr_lo_q      <= addr_lo_d;
      err_q          <= err_d;
      we_q           <= we_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      load_err_q     <= load_err_d;
      instret_q      <= instret_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. Inputs change and outputs are sampled
// on the falling edge; expected write/retire values come from a
// rule-level reference model of loads, ALU writes and the retire count.
module tb_wb_stage;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 64;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] alu;
    logic        is_load;
    logic [2:0]  func;
    logic [1:0]  lo;
    logic [31:0] word;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();
  wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  logic [63:0] model_cnt = 64'd0;
  logic [4:0]  last_rd = 5'd0;
  logic [31:0] last_wdata = 32'd0;

  // Full WRITE-cycle view, and the view that must hold outside WRITE
  wire [135:0] obs_w  = {bus.we, bus.waddr, bus.wdata, bus.retire_valid,
                         bus.retire_pc, bus.load_err, bus.instret};
  wire [103:0] idle_w = {bus.we, bus.retire_valid, bus.load_err,
                         bus.waddr, bus.wdata, bus.instret};

  // Reference model: the write/retire outputs for one instruction
  function automatic logic [135:0] model_write(input instr_t t, input logic [63:0] cnt);
    int unsigned b, h, wd;
    logic [31:0] data;
    logic err;
    wd = t.word;
    b = (wd >> (8 * t.lo)) % 256;
    h = (wd >> (16 * (t.lo / 2))) % 65536;
    err = 1'b0;
    data = t.alu;
    if (t.is_load) begin
      case (t.func)
        3'd0: data = (b >= 128) ? b - 256 : b;
        3'd4: data = b;
        3'd1: if (t.lo % 2 == 1) err = 1'b1; else data = (h >= 32768) ? h - 65536 : h;
        3'd5: if (t.lo % 2 == 1) err = 1'b1; else data = h;
        3'd2: if (t.lo != 0) err = 1'b1; else data = t.word;
        default: err = 1'b1;
      endcase
      if (err) data = 32'd0;
    end
    return {(t.rd_we && t.rd != 5'd0 && !err), t.rd, data, 1'b1, t.pc, err, cnt};
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an instruction for one edge (stage must be ready)
  task automatic drive(input instr_t t);
    bus.in_valid   = 1'b1;
    bus.in_pc      = t.pc;
    bus.in_rd      = t.rd;
    bus.in_rd_we   = t.rd_we;
    bus.in_alu_res = t.alu;
    bus.in_is_load = t.is_load;
    bus.in_ld_func = t.func;
    bus.in_addr_lo = t.lo;
    cycle();
    bus.in_valid   = 1'b0;
    bus.in_alu_res = $urandom;
  endtask

  // Return the memory word after a number of idle wait cycles
  task automatic respond(input logic [31:0] word, input int waits);
    repeat (waits) cycle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = word;
    cycle();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom;
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic rd_we,
                                input logic [31:0] alu, input logic is_load, input logic [2:0] func,
                                input logic [1:0] lo, input logic [31:0] word);
    instr_t t;
    t.pc = pc; t.rd = rd; t.rd_we = rd_we; t.alu = alu;
    t.is_load = is_load; t.func = func; t.lo = lo; t.word = word;
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    checks++;
    if (obs_w !== 136'd0) $display("FAIL reset_outputs: got %h want 0", obs_w);
    else passed++;
    checks++;
    if ({bus.in_ready, bus.mem_rready} !== 2'b10)
      $display("FAIL reset_ready: got %b want 10", {bus.in_ready, bus.mem_rready});
    else passed++;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (obs_w !== 136'd0) $display("FAIL reset_release: got %h want 0", obs_w);
    else passed++;
    model_cnt = 64'd0; last_rd = 5'd0; last_wdata = 32'd0;
  endtask

  task automatic test_addi();
    instr_t t;
    logic [135:0] exp;
    t = mk(32'h0000_0100, 5'd5, 1'b1, 32'h0000_1234, 1'b0, 3'd0, 2'd0, 32'd0);
    drive(t);
    model_cnt++;
    exp = model_write(t, model_cnt);
    checks++;
    if (obs_w !== exp) $display("FAIL addi_write: got %h want %h", obs_w, exp);
    else passed++;
    last_rd = exp[134:130]; last_wdata = exp[129:98];
    cycle();
    checks++;
    if (idle_w !== {3'b000, last_rd, last_wdata, model_cnt})
      $display("FAIL addi_idle: got %h want %h", idle_w, {3'b000, last_rd, last_wdata, model_cnt});
    else passed++;
  endtask

  task automatic test_lb_sign();
    instr_t t;
    logic [135:0] exp;
    t = mk(32'h0000_0200, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1, 3'b000, 2'd2, 32'h0080_FF00);
    drive(t);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.in_ready, bus.mem_rready, bus.we, bus.retire_valid} !== 4'b0100)
        $display("FAIL lb_wait: got %b want 0100",
                 {bus.in_ready, bus.mem_rready, bus.we, bus.retire_valid});
      else passed++;
      cycle();
    end
    respond(t.word, 0);
    model_cnt++;
    exp = model_write(t, model_cnt);
    checks++;
    if (obs_w !== exp || bus.wdata !== 32'hFFFF_FF80) $display("FAIL lb_write: got %h want %h", obs_w, exp);
    else passed++;
    // LBU accepted straight out of WRITE
    t = mk(32'h0000_0204, 5'd8, 1'b1, 32'h0, 1'b1, 3'b100, 2'd2, 32'h0080_FF00);
    drive(t);
    respond(t.word, 1);
    model_cnt++;
    exp = model_write(t, model_cnt);
    checks++;
    if (obs_w !== exp || bus.wdata !== 32'h0000_0080) $display("FAIL lbu_write: got %h want %h", obs_w, exp);
    else passed++;
    last_rd = exp[134:130]; last_wdata = exp[129:98];
    cycle();
  endtask

  task automatic test_load_err();
    instr_t t;
    logic [135:0] exp;
    t = mk(32'h0000_0300, 5'd9, 1'b1, 32'h1111_1111, 1'b1, 3'b001, 2'd1, 32'h1234_5678);
    drive(t);
    respond(t.word, 1);
    model_cnt++;
    exp = model_write(t, model_cnt);
    checks++;
    if (obs_w !== exp || bus.load_err !== 1'b1 || bus.we !== 1'b0)
      $display("FAIL lh_misaligned: got %h want %h", obs_w, exp);
    else passed++;
    t = mk(32'h0000_0304, 5'd10, 1'b1, 32'h2222_2222, 1'b1, 3'b011, 2'd0, 32'h8765_4321);
    drive(t);
    respond(t.word, 2);
    model_cnt++;
    exp = model_write(t, model_cnt);
    checks++;
    if (obs_w !== exp || bus.load_err !== 1'b1 || bus.we !== 1'b0)
      $display("FAIL illegal_func: got %h want %h", obs_w, exp);
    else passed++;
    last_rd = exp[134:130]; last_wdata = exp[129:98];
    cycle();
    checks++;
    if (idle_w !== {3'b000, last_rd, last_wdata, model_cnt})
      $display("FAIL err_idle: got %h want %h", idle_w, {3'b000, last_rd, last_wdata, model_cnt});
    else passed++;
  endtask

  task automatic test_back_to_back();
    instr_t t;
    logic [135:0] exp;
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    model_cnt = 64'd0;
    for (int i = 1; i <= 5; i++) begin
      t = mk(32'h0000_1000 + 32'(4 * i), (i == 5) ? 5'd0 : 5'(i), 1'b1, $urandom, 1'b0, 3'd0, 2'd0, 32'd0);
      drive(t);
      model_cnt++;
      exp = model_write(t, model_cnt);
      checks++;
      if (obs_w !== exp) $display("FAIL b2b_%0d: got %h want %h", i, obs_w, exp);
      else passed++;
      last_rd = exp[134:130]; last_wdata = exp[129:98];
    end
    checks++;
    if (bus.instret !== 64'd5 || bus.we !== 1'b0 || bus.retire_valid !== 1'b1)
      $display("FAIL b2b_count: got instret %0d we %b rv %b want 5 0 1", bus.instret, bus.we, bus.retire_valid);
    else passed++;
    cycle();
  endtask

  task automatic test_rvalid_ignored();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = $urandom;
    repeat (2) cycle();
    checks++;
    if (idle_w !== {3'b000, last_rd, last_wdata, model_cnt} || {bus.in_ready, bus.mem_rready} !== 2'b10)
      $display("FAIL stray_rvalid: got %h want %h", idle_w, {3'b000, last_rd, last_wdata, model_cnt});
    else passed++;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    instr_t t;
    t = mk(32'h0000_2000, 5'd12, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0, 32'hCAFE_F00D);
    drive(t);
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = t.word;
    cycle();
    checks++;
    if (obs_w !== 136'd0) $display("FAIL reset_mid_load: got %h want 0", obs_w);
    else passed++;
    checks++;
    if ({bus.in_ready, bus.mem_rready} !== 2'b10)
      $display("FAIL reset_mid_ready: got %b want 10", {bus.in_ready, bus.mem_rready});
    else passed++;
    bus.mem_rvalid = 1'b0;
    model_cnt = 64'd0; last_rd = 5'd0; last_wdata = 32'd0;
  endtask

  task automatic test_random();
    instr_t t;
    logic [135:0] exp;
    for (int i = 0; i < 80; i++) begin
      t = mk($urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             ($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 3'($urandom),
             2'($urandom), $urandom);
      drive(t);
      if (t.is_load) respond(t.word, $urandom_range(0, 3));
      model_cnt++;
      exp = model_write(t, model_cnt);
      checks++;
      if (obs_w !== exp) $display("FAIL rand_%0d: got %h want %h", i, obs_w, exp);
      else passed++;
      last_rd = exp[134:130]; last_wdata = exp[129:98];
      if ($urandom_range(0, 1) == 1) begin
        cycle();
        checks++;
        if (idle_w !== {3'b000, last_rd, last_wdata, model_cnt})
          $display("FAIL rand_idle_%0d: got %h want %h", i, idle_w, {3'b000, last_rd, last_wdata, model_cnt});
        else passed++;
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = 32'd0; bus.in_rd = 5'd0; bus.in_rd_we = 1'b0;
    bus.in_alu_res = 32'd0; bus.in_is_load = 1'b0; bus.in_ld_func = 3'd0;
    bus.in_addr_lo = 2'd0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_lb_sign();
    test_load_err();
    test_back_to_back();
    test_rvalid_ignored();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the single-issue NPC core. It sits directly upstream of the general register file and drives its write port (we/waddr/wdata).
- Accepts one completed instruction per handshake from the EX/MEM side and waits on a valid/ready memory read response for loads.
- Extracts and extends load data, then issues exactly one register write and one retire pulse per instruction.
- Keeps the 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath and register width
- RA_W, 5, register address width
- CNT_W, 64, instret counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rd  in  RA_W  destination register
- in_rd_we  in  1  instruction writes rd
- in_alu_res  in  XLEN  ALU result (non-load write value)
- in_is_load  in  1  instruction is a load
- in_ld_func  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- in_addr_lo  in  2  load effective address bits [1:0]
- mem_rvalid  in  1  memory read data valid
- mem_rready  out  1  stage accepts memory read data
- mem_rdata  in  XLEN  aligned 32-bit memory word
- we  out  1  register file write enable
- waddr  out  RA_W  register file write address
- wdata  out  XLEN  register file write data
- retire_valid  out  1  one-cycle retire pulse
- retire_pc  out  XLEN  PC of the retiring instruction
- load_err  out  1  one-cycle pulse: illegal ld_func or misaligned load
- instret  out  CNT_W  retired instruction count

Behaviour:
- FSM states: IDLE, WAIT_MEM, WRITE. Reset: state=IDLE; all latched fields, instret, and every output = 0.
- in_ready = (state==IDLE) || (state==WRITE). mem_rready = (state==WAIT_MEM).
- Accept = in_valid && in_ready. On accept, latch pc, rd, rd_we, alu_res, ld_func, addr_lo.
  - Next state is WAIT_MEM if in_is_load, else WRITE.
  - No accept from IDLE: stay IDLE. No accept from WRITE: go to IDLE.
- WAIT_MEM: hold until mem_rvalid. On mem_rvalid, compute the result into the latched value and go to WRITE. mem_rdata is sampled only on that edge.
  - LB/LBU: byte at addr_lo*8, sign/zero-extended.
  - LH/LHU: halfword at addr_lo[1]*16, sign/zero-extended.
  - LW: full word.
  - Error cases: LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or ld_func in {011,110,111}. Result = 0, error flag set, rd write suppressed.
- WRITE lasts exactly one cycle. Outputs are driven from latched registers only (no combinational path from in_* or mem_*):
  - we = rd_we && rd!=0 && !err; waddr = rd; wdata = result.
  - retire_valid = 1; retire_pc = pc; load_err = err.
  - instret increments by 1 on the WRITE cycle, wrapping at 2^CNT_W.
- Outside WRITE: we = 0, retire_valid = 0, load_err = 0. waddr and wdata hold their last values.
- Latency:
  - Non-load accepted at edge N: WRITE (we high) during cycle N+1.
  - Load: mem_rvalid sampled at edge M: WRITE during cycle M+1.
- Back-to-back: an accept during WRITE is allowed, giving 1 instruction/cycle for non-loads. The new instruction's fields overwrite the latches at the same edge that WRITE ends.
- Stores and branches (rd_we=0): still retire and increment instret, with we=0. rd=0 writes also retire with we=0.
- mem_rvalid while not in WAIT_MEM: ignored.
- Reset asserted mid-operation (any state): at the next edge, state=IDLE and outputs cleared. A pending load is abandoned with no write and no retire. instret is cleared.

Test Plan:
- ADDI-like: in_valid, rd=5, rd_we=1, alu_res=0x0000_1234, is_load=0 -> next cycle we=1, waddr=5, wdata=0x1234, retire_valid=1, instret=1.
- LB sign: ld_func=000, addr_lo=2, mem_rvalid after 3 cycles with mem_rdata=0x0080_FF00 -> in_ready=0 while waiting; wdata=0xFFFF_FF80 one cycle after rvalid. Same word with LBU -> 0x0000_0080.
- LH at addr_lo=1 -> load_err=1, we=0, retire_valid=1. ld_func=011 -> same response.
- Back-to-back: 4 non-loads on consecutive cycles (rd=1..4), then rd=0 with rd_we=1 -> 4 consecutive we pulses, fifth cycle we=0 with retire_valid=1, instret=5.
- Reset during WAIT_MEM, then mem_rvalid=1 -> no we, no retire, mem_rready=0, instret=0, in_ready=1.
